arbiter_grant_mux: RTL
======================

Name: arbiter_grant_mux

Overview:
- Downstream stage of the 4-way round-robin arbiter (`arbiter`, ports gnt3..gnt0).
- Consumes the one-hot grant and captures the granted client's data word into a single registered output channel with valid/ready handshake.
- Returns a one-cycle ack to the served client.
- Keeps saturating per-client service counters and a sticky flag for grant-protocol violations.

Parameters:
- DATA_W, 8, width of each client data word and of out_data.
- CNT_W, 8, width of each per-client service counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  reset, synchronous and active-high.
- gnt3, gnt2, gnt1, gnt0  input  1 each  grants from the arbiter, expected one-hot or zero.
- data3, data2, data1, data0  input  DATA_W each  per-client data word, sampled only when that client is granted.
- out_valid  output  1  out_data/out_id hold a beat.
- out_ready  input  1  sink accepts the beat when high with out_valid.
- out_data  output  DATA_W  captured data word.
- out_id  output  2  index of the client that owns out_data.
- ack3, ack2, ack1, ack0  output  1 each  one-cycle pulse: that client's beat was accepted by the sink.
- stat_sel  input  2  selects the counter shown on stat_cnt.
- stat_cnt  output  CNT_W  service count of client stat_sel.
- err_multi  output  1  sticky: more than one grant was seen high in the same cycle.

Behaviour:
- Single clock. Reset is synchronous and active-high; clock port is named clk, reset port is named rst.
- Reset value of every output is 0: out_valid, out_data, out_id, ack3..ack0, err_multi, and all counters, so stat_cnt reads 0.
- Reset mid-operation discards any held beat. No ack is issued for it.
- States:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- "Single grant" means exactly one of gnt3..gnt0 is high. id = index of that grant.
- IDLE transitions:
  - Single grant at edge N: out_data<=data[id], out_id<=id, go to HOLD. out_valid is high in cycle N+1, i.e. one-cycle capture latency.
  - Zero grants: stay in IDLE.
  - Two or more grants: set err_multi, capture nothing, stay in IDLE.
- HOLD:
  - out_data and out_id stay stable until the handshake (out_valid & out_ready).
  - Grants are ignored while no handshake occurs. A grant deasserting in HOLD does not cancel the held beat.
  - On handshake at edge N:
    - ack[out_id] <= 1 for exactly cycle N+1.
    - cnt[out_id] increments, saturating at 2^CNT_W-1 (no wrap).
    - If a single grant is also present at edge N: capture the new beat in the same edge and stay in HOLD. out_valid stays high, giving back-to-back throughput of 1 beat/cycle.
    - Otherwise go to IDLE.
    - If multiple grants are present at edge N: set err_multi, go to IDLE.
- err_multi is set whenever two or more grants are high at an edge where the grant would be sampled (IDLE, or HOLD with handshake). It is cleared only by rst.
- ack outputs are registered and at most one is high per cycle.
- stat_cnt is a combinational read of cnt[stat_sel]; no latency.
- Counter increment and capture of the same client in one edge are independent: both take effect.

Test Plan:
- Reset/idle: hold rst=1 for 5 cycles with gnt0=1 and data0=8'hAA. Required response: out_valid=0, all acks 0, err_multi=0, stat_cnt=0 for every stat_sel.
- Single transfer:
  - Drive gnt1=1, data1=8'h5C at edge N, with out_ready=1 from N+1.
  - Cycle N+1: out_valid=1, out_data=8'h5C, out_id=1.
  - Cycle N+2: ack1=1 (one cycle only).
  - With stat_sel=1: stat_cnt=1.
- Backpressure:
  - Grant client 2 (data2=8'h11) with out_ready=0 for 4 cycles while data2 changes to 8'h22 and gnt2 drops.
  - Required: out_data stays 8'h11 and out_valid stays 1.
  - After out_ready=1, exactly one ack2 pulse; counter for client 2 becomes 1.
- Back-to-back:
  - With out_ready=1, sequence gnt0, gnt1, gnt2, gnt3 on consecutive edges with data = 8'h01..8'h04.
  - Required: out_valid stays 1 for 4 cycles; out_id=0,1,2,3; out_data=8'h01..8'h04.
  - ack0..ack3 pulse in consecutive cycles; each counter reads 1.
- Protocol error: drive gnt0=1 and gnt3=1 together in IDLE. Required: err_multi=1 from the next cycle and stays high; out_valid remains 0; no acks. Only rst clears err_multi.
- Saturation: with CNT_W=2, serve client 0 five times. Required: stat_cnt (stat_sel=0) reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/arbiter_grant_mux.sv
// rtl/arbiter_grant_mux.sv - captures the granted client's word into one registered valid/ready channel
// Also issues per-client acks, keeps saturating service counters and a sticky multi-grant flag.
module arbiter_grant_mux #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt3,
    input  logic              gnt2,
    input  logic              gnt1,
    input  logic              gnt0,
    input  logic [DATA_W-1:0] data3,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_id,
    output logic              ack3,
    output logic              ack2,
    output logic              ack1,
    output logic              ack0,
    input  logic [1:0]        stat_sel,
    output logic [CNT_W-1:0]  stat_cnt,
    output logic              err_multi
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        ack_q;
    logic [CNT_W-1:0]  cnt [4];

    logic [2:0]        gnt_count;
    logic              gnt_single;
    logic              gnt_multi;
    logic [1:0]        gnt_id;
    logic [DATA_W-1:0] gnt_data;
    logic              handshake;

    assign gnt_count  = {2'b00, gnt3} + {2'b00, gnt2} + {2'b00, gnt1} + {2'b00, gnt0};
    assign gnt_single = (gnt_count == 3'd1);
    assign gnt_multi  = (gnt_count >= 3'd2);
    assign handshake  = out_valid & out_ready;

    // Encoding is only meaningful when exactly one grant is high.
    always_comb begin
        gnt_id = 2'd0;
        if (gnt1) gnt_id = 2'd1;
        if (gnt2) gnt_id = 2'd2;
        if (gnt3) gnt_id = 2'd3;
    end

    always_comb begin
        gnt_data = data0;
        case (gnt_id)
            2'd0: gnt_data = data0;
            2'd1: gnt_data = data1;
            2'd2: gnt_data = data2;
            2'd3: gnt_data = data3;
            default: gnt_data = data0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 2'd0;
            ack_q     <= 4'd0;
            err_multi <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ack_q <= 4'd0;
            case (state)
                IDLE: begin
                    if (gnt_single) begin
                        out_data  <= gnt_data;
                        out_id    <= gnt_id;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (gnt_multi) begin
                        err_multi <= 1'b1;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        ack_q <= 4'd1 << out_id;
                        if (cnt[out_id] != {CNT_W{1'b1}}) begin
                            cnt[out_id] <= cnt[out_id] + 1'b1;
                        end
                        // A grant present on the accepting edge refills the slot for 1 beat/cycle.
                        if (gnt_single) begin
                            out_data <= gnt_data;
                            out_id   <= gnt_id;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                            if (gnt_multi) begin
                                err_multi <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign ack3     = ack_q[3];
    assign ack2     = ack_q[2];
    assign ack1     = ack_q[1];
    assign ack0     = ack_q[0];
    assign stat_cnt = cnt[stat_sel];

endmodule
